// File: rtl/seven_segment_scan.sv
// seven_segment_scan
// Multiplexed multi-digit seven-segment display driver. A load strobe captures
// per-digit nibbles, decimal points, blank and blink masks into shadow
// registers. The scan logic then drives one digit at a time onto the shared
// cathode bus and the per-digit anodes.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active-low
//   load       in   capture strobe for value/dp_in/blank/blink
//   value      in   4*DIGITS packed nibbles, digit 0 in bits [3:0] (rightmost)
//   dp_in      in   DIGITS decimal point requests, active-high
//   blank      in   DIGITS force-dark mask, active-high
//   blink      in   DIGITS blink enable mask, active-high
//   seg        out  {CA..CG} cathodes, active-low, registered
//   dp         out  decimal point cathode, active-low, registered
//   an         out  DIGITS anodes, active-low, at most one low, registered
//   frame_done out  one-cycle pulse per completed scan frame
module seven_segment_scan #(
    parameter int DIGITS          = 4,
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int BLINK_FRAMES    = 64,
    parameter bit ONEHOT          = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     blink,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int TW = $clog2(TICKS_PER_DIGIT);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_DIGIT - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } phase_t;

    logic [4*DIGITS-1:0] shValue_q;
    logic [DIGITS-1:0]   shDp_q, shBlank_q, shBlink_q;

    logic [TW-1:0] tick_q, tick_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [FW-1:0] frame_q, frame_d;
    phase_t        phase_q, phase_d;

    logic [6:0]        seg_q, seg_d;
    logic              dpOut_q, dpOut_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              frameDone_q, frameDone_d;

    logic       tickWrap, idxWrap, frameWrap;
    logic [3:0] curNibble;
    logic       visible;
    logic [6:0] hexCode, ohCode, code;
    logic       ohValid, codeValid;

    // Hex glyphs in {CA..CG} order, active-low.
    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Shadow registers; the reset blank mask keeps the display dark until the
    // first load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shValue_q <= '0;
            shDp_q    <= '0;
            shBlank_q <= '1;
            shBlink_q <= '0;
        end else if (load) begin
            shValue_q <= value;
            shDp_q    <= dp_in;
            shBlank_q <= blank;
            shBlink_q <= blink;
        end
    end

    // Scan counters: tick within a digit slot, digit index, frames within a
    // blink half-period, and the blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q  <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            phase_q <= PHASE_ON;
        end else begin
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    // Next-state for the counters; each wrap cascades into the next counter
    // on the same edge.
    always_comb begin
        tickWrap  = (tick_q == TICK_LAST);
        idxWrap   = tickWrap && (idx_q == IDX_LAST);
        frameWrap = idxWrap && (frame_q == FRAME_LAST);

        tick_d  = tickWrap ? '0 : tick_q + 1'b1;
        idx_d   = idx_q;
        frame_d = frame_q;
        phase_d = phase_q;

        if (tickWrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (idxWrap) begin
            frame_d = frameWrap ? '0 : frame_q + 1'b1;
        end
        if (frameWrap) begin
            phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
        end
    end

    // Output values for the selected digit. In one-hot mode an invalid
    // nibble also keeps the anode high so nothing stale is shown.
    always_comb begin
        curNibble = shValue_q[{idx_q, 2'b00} +: 4];
        visible   = !shBlank_q[idx_q] && !(shBlink_q[idx_q] && (phase_q == PHASE_OFF));
        hexCode   = hexSeg(curNibble);

        ohValid = 1'b1;
        ohCode  = 7'b1111111;
        case (curNibble)
            4'b0001: ohCode = hexSeg(4'h1);
            4'b0010: ohCode = hexSeg(4'h2);
            4'b0100: ohCode = hexSeg(4'h3);
            4'b1000: ohCode = hexSeg(4'h4);
            default: ohValid = 1'b0;
        endcase

        codeValid = ONEHOT ? ohValid : 1'b1;
        code      = ONEHOT ? ohCode : hexCode;

        seg_d   = (visible && codeValid) ? code : 7'b1111111;
        dpOut_d = visible ? ~shDp_q[idx_q] : 1'b1;

        an_d = '1;
        if ((tick_q != '0) && visible && codeValid) begin
            an_d[idx_q] = 1'b0;
        end

        frameDone_d = idxWrap;
    end

    // Registered outputs, one cycle behind the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= 7'h7F;
            dpOut_q     <= 1'b1;
            an_q        <= '1;
            frameDone_q <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            dpOut_q     <= dpOut_d;
            an_q        <= an_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dpOut_q;
    assign an         = an_q;
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// tb_seven_segment_scan
// Drives a hex-mode and a one-hot-mode instance from shared inputs and
// compares every cycle against a reference model computed from the cycle
// count since reset release. Directed scenarios are mixed with random loads.
module tb_seven_segment_scan;

    localparam int D     = 4;
    localparam int T     = 4;
    localparam int BF    = 2;
    localparam int FRAME = D * T;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dpIn, blank, blink;

    logic [6:0] seg0, seg1;
    logic       dp0, dp1, fd0, fd1;
    logic [3:0] an0, an1;

    seven_segment_scan #(.DIGITS(D), .TICKS_PER_DIGIT(T), .BLINK_FRAMES(BF), .ONEHOT(1'b0)) dutHex (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dpIn),
        .blank(blank), .blink(blink), .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0)
    );

    seven_segment_scan #(.DIGITS(D), .TICKS_PER_DIGIT(T), .BLINK_FRAMES(BF), .ONEHOT(1'b1)) dutOneHot (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dpIn),
        .blank(blank), .blink(blink), .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1)
    );

    int testCount = 0;
    int failCount = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    logic [6:0] hexTable [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int          mCyc, tk, ix, ph, nib;
    bit          vis, ohValid;
    logic [6:0]  ohCode, eSeg0, eSeg1;
    logic        eDp0, eDp1, eFd;
    logic [3:0]  eAn0, eAn1;
    logic [15:0] mVal;
    logic [3:0]  mDp, mBlank, mBlink;

    // Reference model: the output after edge m shows the digit selected
    // during cycle m-1 of the scan, using the shadow contents at that time.
    always begin : refModel
        @(posedge clk);
        if (!rst_n) begin
            mCyc = 0; mVal = '0; mDp = '0; mBlank = '1; mBlink = '0;
            eSeg0 = 7'h7F; eSeg1 = 7'h7F; eDp0 = 1'b1; eDp1 = 1'b1;
            eAn0 = 4'hF; eAn1 = 4'hF; eFd = 1'b0;
        end else begin
            tk  = mCyc % T;
            ix  = (mCyc / T) % D;
            ph  = (mCyc / FRAME / BF) % 2;
            nib = int'((mVal >> (4 * ix)) & 16'hF);
            vis = !mBlank[ix] && !(mBlink[ix] && ph == 1);
            ohValid = (nib == 1) || (nib == 2) || (nib == 4) || (nib == 8);
            ohCode  = (nib == 1) ? hexTable[1] : (nib == 2) ? hexTable[2] :
                      (nib == 4) ? hexTable[3] : (nib == 8) ? hexTable[4] : 7'h7F;
            eSeg0 = vis ? hexTable[nib] : 7'h7F;
            eSeg1 = (vis && ohValid) ? ohCode : 7'h7F;
            eDp0  = vis ? !mDp[ix] : 1'b1;
            eDp1  = eDp0;
            eAn0  = (tk == 0 || !vis) ? 4'hF : 4'(~(4'b0001 << ix));
            eAn1  = (tk == 0 || !vis || !ohValid) ? 4'hF : 4'(~(4'b0001 << ix));
            if (load) begin
                mVal = value; mDp = dpIn; mBlank = blank; mBlink = blink;
            end
            mCyc++;
            eFd = (mCyc % FRAME) == 0;
        end
        #1;
        checkOutput("hex_seg", 32'(seg0), 32'(eSeg0));
        checkOutput("hex_dp",  32'(dp0),  32'(eDp0));
        checkOutput("hex_an",  32'(an0),  32'(eAn0));
        checkOutput("hex_fd",  32'(fd0),  32'(eFd));
        checkOutput("oh_seg",  32'(seg1), 32'(eSeg1));
        checkOutput("oh_dp",   32'(dp1),  32'(eDp1));
        checkOutput("oh_an",   32'(an1),  32'(eAn1));
        checkOutput("oh_fd",   32'(fd1),  32'(eFd));
    end

    // Loads one set of shadow values with a single-cycle strobe; called at a
    // falling edge and returns at the next falling edge.
    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d,
                                 input logic [3:0] bl, input logic [3:0] bk);
        value = v; dpIn = d; blank = bl; blink = bk; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Waits (bounded) until the chosen instance drives the given anode pattern.
    task automatic waitForAnode(input bit oneHot, input logic [3:0] pattern, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(posedge clk);
            #1;
            found = oneHot ? (an1 == pattern) : (an0 == pattern);
        end
        checkOutput(tag, 32'(found), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        int firstFd, secondFd;
        logic [15:0] rv;

        rst_n = 1'b0; load = 1'b0; value = '0; dpIn = '0; blank = '0; blink = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_seg", 32'(seg0), 32'h7F);
        checkOutput("reset_an",  32'(an0),  32'hF);
        checkOutput("reset_fd",  32'(fd0),  32'h0);
        rst_n = 1'b1;

        // frame_done timing after release, no load
        firstFd = 0; secondFd = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (fd0) begin
                if (firstFd == 0) firstFd = i;
                else if (secondFd == 0) secondFd = i;
            end
        end
        checkOutput("first_frame_done",  32'(firstFd),  32'd16);
        checkOutput("second_frame_done", 32'(secondFd), 32'd32);

        // hex scan
        @(negedge clk);
        applyStimulus(16'h3A70, 4'b0100, 4'b0000, 4'b0000);
        waitForAnode(1'b0, 4'b1011, "wait_digit2");
        checkOutput("digit2_seg", 32'(seg0), 32'(7'b0001000));
        checkOutput("digit2_dp",  32'(dp0),  32'd0);
        waitForAnode(1'b0, 4'b1110, "wait_digit0");
        checkOutput("digit0_seg", 32'(seg0), 32'(7'b0000001));

        // blink on digit 0 across several half-periods
        @(negedge clk);
        applyStimulus(16'h3A70, 4'b0100, 4'b0000, 4'b0001);
        repeat (6 * FRAME) @(negedge clk);

        // one-hot decode
        applyStimulus(16'h8421, 4'b0000, 4'b0000, 4'b0000);
        waitForAnode(1'b1, 4'b0111, "wait_oh_digit3");
        checkOutput("oh_digit3_seg", 32'(seg1), 32'(7'b1001100));
        @(negedge clk);
        applyStimulus(16'h0003, 4'b0000, 4'b0000, 4'b0000);
        repeat (2 * FRAME) @(negedge clk);

        // load during the digit 2 slot
        applyStimulus(16'h3A70, 4'b0000, 4'b0000, 4'b0000);
        waitForAnode(1'b0, 4'b1011, "wait_slot2");
        @(negedge clk);
        value = 16'h3570; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midslot_an",  32'(an0),  32'(4'b1011));
        checkOutput("midslot_seg", 32'(seg0), 32'(7'b0100100));
        @(negedge clk);
        value = 16'hFFFF; dpIn = 4'hF;
        repeat (FRAME) @(negedge clk);
        waitForAnode(1'b0, 4'b1011, "wait_noload");
        checkOutput("noload_seg", 32'(seg0), 32'(7'b0100100));

        // randomized loads and non-loaded input churn
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                int r;
                r = $urandom_range(0, 5);
                rv[4*k +: 4] = (r < 4) ? 4'(1 << r) : 4'($urandom_range(0, 15));
            end
            value = rv;
            dpIn  = 4'($urandom);
            blank = 4'($urandom & $urandom & $urandom);
            blink = 4'($urandom & $urandom);
            load  = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        load = 1'b0;

        // reset during digit 3
        applyStimulus(16'h1234, 4'b1010, 4'b0000, 4'b0000);
        waitForAnode(1'b0, 4'b0111, "wait_digit3");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_an",  32'(an0),  32'hF);
        checkOutput("midreset_seg", 32'(seg0), 32'h7F);
        checkOutput("midreset_dp",  32'(dp0),  32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("after_reset_an", 32'(an0), 32'hF);
        applyStimulus(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        repeat (2 * FRAME) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Multiplexed multi-digit seven-segment display driver for the Spartan Elevator board. It captures a packed set of per-digit nibbles, then time-multiplexes them onto the shared cathode bus and per-digit anodes. It supports per-digit blanking, blinking and decimal points, with either hex or one-hot floor decoding. It replaces the single-digit, one-hot-only decoder and sits between the elevator controller (floor/status values) and the board's display pins.

## Interface
- `DIGITS`, 4, number of multiplexed digits (1..8).
- `TICKS_PER_DIGIT`, 50000, clk cycles each digit is selected (≥2).
- `BLINK_FRAMES`, 64, full scan frames per blink half-period (≥1).
- `ONEHOT`, 0, decode mode. 0 = hex 0-F. 1 = one-hot floor: 0001→1, 0010→2, 0100→3, 1000→4, any other nibble → dark.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `load`  in  1  capture strobe for `value`, `dp_in`, `blank` and `blink` into shadow registers.
- `value`  in  4*DIGITS  nibble i in bits [4i+3:4i]; digit 0 = rightmost.
- `dp_in`  in  DIGITS  decimal point request per digit, active-high.
- `blank`  in  DIGITS  force digit dark, active-high.
- `blink`  in  DIGITS  digit dark during the blink-off phase, active-high.
- `seg`  out  7  {CA,CB,CC,CD,CE,CF,CG}, active-low, registered.
- `dp`  out  1  decimal point cathode, active-low, registered.
- `an`  out  DIGITS  anodes, active-low, at most one low, registered.
- `frame_done`  out  1  one-cycle pulse per completed scan frame.

## Operation
- **Shadow capture.** On any rising edge with `load`=1, all four shadow registers are loaded. The scan logic reads only the shadow registers. Inputs changing while `load`=0 have no effect.
- **Tick counter.** `tick` counts 0..TICKS_PER_DIGIT-1. At the terminal count it wraps to 0 and `idx` advances by 1.
- **Digit index.** `idx` counts 0..DIGITS-1 and wraps DIGITS-1→0. That wrap edge also registers `frame_done`=1 for exactly one cycle.
- **Blink phase.** A frame counter counts `frame_done` events 0..BLINK_FRAMES-1. At its wrap it toggles `phase` (0 = on, 1 = off).
- **Visibility.** Digit `idx` is visible iff !blank[idx] && !(blink[idx] && phase).
- **Output register.** Each edge loads the outputs from the current (`idx`, `tick`, `phase`, shadow) values:
  - `an`: all 1s when `tick`==0 (anti-ghosting gap) or the digit is invisible; otherwise bit `idx`=0 and all other bits 1.
  - `seg`: decode of nibble `idx` when visible, else 7'b1111111.
  - `dp`: ~dp_in[idx] when visible, else 1.
- **Hex table (CA..CG).**
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- **One-hot mode.** Digits 1-4 use the same codes as the hex table. Invalid nibbles, including 0000 and multi-hot values, give 1111111. The output never holds a stale value.
- **Counter widths.** Each counter is sized with $clog2 of its terminal value. There is no overflow beyond the terminal values.

## Timing
- **Reset state (asynchronous, immediate).**
  - `seg`=7'h7F, `dp`=1, `an`=all 1s, `frame_done`=0.
  - `tick`=0, `idx`=0, frame counter=0, `phase`=0.
  - Shadow `value`=0, `dp`=0, `blink`=0, `blank`=all 1s, so the display stays dark until the first `load`.
- **Reset release.** The first scan edge follows the first rising clk after `rst_n` deasserts.
- **Output latency.** Outputs lag `idx`/`tick` by one cycle. A digit's anode is low for TICKS_PER_DIGIT-1 cycles per slot, preceded by 1 dark cycle.
- **Load latency.** `load` at edge k means shadow is valid after edge k, and `seg` reflects it from edge k+1 if that digit is selected.
- **Load at a frame boundary.** A `load` coincident with a `tick` wrap or `idx` wrap is honoured. Both actions happen on that edge.
- **Frame period.** DIGITS*TICKS_PER_DIGIT cycles. `frame_done` is high exactly one cycle per frame.
- **Blink period.** One blink half-period is BLINK_FRAMES frames.
- **Reset mid-scan.** All state returns to reset values. No partial frame produces `frame_done`.

## Test plan
Unless stated otherwise: DIGITS=4, TICKS_PER_DIGIT=4, BLINK_FRAMES=2, ONEHOT=0.
- **Reset.** Hold `rst_n`=0 for 3 cycles, then release with no `load` → `seg`=7F and `an`=F continuously. The first `frame_done` occurs 16 cycles after release and then repeats every 16 cycles.
- **Hex scan.** `load` with `value`=16'h3A70 and `dp_in`=4'b0100, `blank`=`blink`=0 → per slot, 1 cycle with `an`=F, then 3 cycles of:
  - `an`=1110, `seg`=0000001
  - `an`=1101, `seg`=0001111
  - `an`=1011, `seg`=0001000, `dp`=0
  - `an`=0111, `seg`=0000110
- **Blink.** `blink`=4'b0001 → digit 0 lit for frames 0-1, dark for frames 2-3, lit for frames 4-5. Other digits are unaffected.
- **One-hot mode (ONEHOT=1).** `value`=16'h8421 → digits show 1, 2, 3, 4. Then `load` `value`=16'h0003 → digit 0 shows 1111111 and its anode stays high.
- **Load during scan.** Pulse `load` while `idx`=2 to change only digit 2 → the new code appears within that same slot starting the next cycle. Inputs changed without `load` → display unchanged.
- **Reset mid-scan.** Assert `rst_n` during `idx`=3 → outputs go dark in the same cycle. After release, the scan restarts at digit 0 with the display blank until the next `load`.
